dmem_responder: RTL and testbench
=================================

# dmem_responder

Multicycle, pipelined data-memory responder: the memory-side end of the CPU's load/store interface. The MEM stage issues one request per cycle (read or write, 16-bit byte address, 16-bit data), and this block returns an in-order response exactly LATENCY cycles later. Back-pressure from the CPU freezes the whole pipe. It replaces the single-cycle data memory and is the target the cache/stall logic will be built against.

## Interface
- LATENCY, 4, cycles from request acceptance to response presentation; legal range 1..8
- DEPTH_LOG2, 10, log2 of memory depth in 16-bit words
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  16  byte address; bit 0 ignored; word index = req_addr[DEPTH_LOG2:1]; higher bits ignored (alias)
- req_wdata  in  16  store data
- req_ready  out  1  request is accepted at this edge if req_valid && req_ready
- resp_valid  out  1  response present
- resp_write  out  1  response belongs to a store
- resp_addr  out  16  req_addr of the request being answered, unmodified
- resp_data  out  16  load data; for stores, the data written
- resp_ready  in  1  CPU consumes the response at this edge if resp_valid && resp_ready
- inflight  out  4  number of valid pipe stages, including the output stage

## Operation
- Pipe: LATENCY stages. Each stage holds {valid, write, addr, data}. Stage LATENCY drives the resp_* outputs. resp_valid = stage LATENCY valid.
- stall = resp_valid && !resp_ready.
- req_ready = !stall. This is combinational from resp_ready; there is no other throttling.
- Accept: when req_valid && req_ready at an edge:
  - Store: the array word is written at that edge. Stage 1 loads {1, 1, addr, req_wdata}.
  - Load: the array word is read before that edge's update and loaded into stage 1 as {1, 0, addr, mem[idx]}.
- Advance (on any non-stall edge):
  - every stage shifts by one;
  - stage 1 loads either the accepted request or a bubble (valid = 0);
  - the output stage is overwritten, so an unconsumed response cannot be lost, because the pipe only moves when not stalled.
- Stall edge: all stages hold, and no array write occurs.
- Bubbles are not squeezed. Order is strictly first-in, first-out.
- Hazards: a load accepted one or more edges after a store to the same word returns the new data. Only one request is accepted per edge, so there are no same-edge hazards.
- inflight counts the valid bits across all stages and updates each edge. Maximum value is LATENCY.
- The array is not reset; contents are undefined until written.

## Timing
- Reset (rst = 1 at an edge):
  - all stage valid bits clear;
  - resp_valid = 0, resp_write = 0, resp_addr = 0, resp_data = 0, inflight = 0;
  - req_ready = 1 in the following cycle.
  - A request presented in the same cycle that rst is high is ignored, with no array write.
- Reset mid-operation: in-flight responses are discarded. Stores already accepted at earlier edges remain in the array.
- Latency: a request accepted at edge t has resp_valid high in the cycle after edge t+LATENCY-1, provided no stall intervenes. Each stall edge adds one cycle.
- Throughput: one request per cycle sustained while resp_ready = 1.
- Edge with simultaneous consume and accept: both occur, the pipe advances, and inflight is unchanged if a bubble is not leaving.
- resp_* outputs are stable for as long as resp_valid && !resp_ready holds.
- Address wrap: with DEPTH_LOG2 = 10, byte addresses 0x0000 and 0x0800 map to the same word.

## Test plan
- Reset: hold rst for 2 edges with req_valid = 1 and a store request present -> resp_valid = 0, inflight = 0, req_ready = 1 after release. A later load of that address must not return the ignored store's data.
- Store then load: store 0x1234 to 0x0010 at edge 5, then load 0x0010 at edge 6, with resp_ready = 1 -> edge-5 response (write, data 0x1234) visible after edge 8; edge-6 response (read, 0x1234) visible after edge 9.
- Streaming: stores 0xA000..0xA003 to 0x20/0x22/0x24/0x26, then 4 back-to-back loads -> 4 consecutive load responses in order, data 0xA000..0xA003, inflight steady at 4.
- Back-pressure: during the stream, drop resp_ready for 3 cycles -> req_ready = 0 for those 3 cycles, resp_* held constant, no response dropped or duplicated, total latency grows by exactly 3.
- Alias: store 0xBEEF to 0x0800, then load 0x0000 -> load returns 0xBEEF, and resp_addr = 0x0000.
- Reset in flight: 3 loads outstanding, assert rst for 1 edge -> resp_valid = 0 with no stale responses afterwards. A store accepted before the reset is still readable after it.

Source files
------------

// File: rtl/dmem_responder.sv
// Pipelined data-memory responder: in-order load/store responses, fixed depth pipe.
// Latency: LATENCY cycles from acceptance to resp_valid; a stall adds one cycle per stall edge.
// Backpressure: resp_valid && !resp_ready freezes every stage and drops req_ready combinationally.
module dmem_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic        resp_write,
    output logic [15:0] resp_addr,
    output logic [15:0] resp_data,
    input  logic        resp_ready,
    output logic [3:0]  inflight
);

    typedef struct packed {
        logic        vld;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } stage_t;

    stage_t                  stg_q [LATENCY];
    stage_t                  stg_d [LATENCY];
    logic [15:0]             mem   [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    stall;
    logic                    accept;
    logic [3:0]              cnt;
    logic                    unused_addr_bits;

    // Bit 0 and the bits above the word index alias onto the same word.
    assign idx              = req_addr[DEPTH_LOG2:1];
    assign unused_addr_bits = ^{req_addr[15:DEPTH_LOG2+1], req_addr[0]};

    assign stall     = stg_q[LATENCY-1].vld && !resp_ready;
    assign req_ready = !stall;
    assign accept    = req_valid && !stall;

    always_comb begin
        stg_d = stg_q;
        if (!stall) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                stg_d[i] = stg_q[i-1];
            end
            stg_d[0] = '0;
            if (accept) begin
                stg_d[0].vld  = 1'b1;
                stg_d[0].wr   = req_write;
                stg_d[0].addr = req_addr;
                // Loads see the array before this edge's write; only one request per edge.
                stg_d[0].data = req_write ? req_wdata : mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_q <= stg_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept && req_write) begin
            mem[idx] <= req_wdata;
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            cnt = cnt + {3'b000, stg_q[i].vld};
        end
    end

    assign inflight   = cnt;
    assign resp_valid = stg_q[LATENCY-1].vld;
    assign resp_write = stg_q[LATENCY-1].wr;
    assign resp_addr  = stg_q[LATENCY-1].addr;
    assign resp_data  = stg_q[LATENCY-1].data;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected responses, a monitor pops them.
module tb_dmem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_write;
    logic [15:0] resp_addr;
    logic [15:0] resp_data;
    logic        resp_ready;
    logic [3:0]  inflight;

    dmem_responder #(.LATENCY(LAT), .DEPTH_LOG2(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_write (resp_write),
        .resp_addr  (resp_addr),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .inflight   (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          acc_edge;
        int          stall_at;
    } exp_t;

    exp_t        sb[$];
    int          cyc         = 0;
    int          stall_edges = 0;
    int          n_pass      = 0;
    int          n_total     = 0;
    logic        prev_stall  = 1'b0;
    logic        held_wr;
    logic [15:0] held_addr;
    logic [15:0] held_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    endtask

    // Monitor: consume-side checks, stall stability and stall bookkeeping.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_write", resp_write, held_wr);
                chk("hold_addr", resp_addr, held_addr);
                chk("hold_data", resp_data, held_data);
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_resp: got addr %h data %h expected none", resp_addr, resp_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_write", resp_write, e.wr);
                    chk("resp_addr", resp_addr, e.addr);
                    chk("resp_data", resp_data, e.data);
                    chk("latency_edge", cyc + 1, e.acc_edge + LAT + (stall_edges - e.stall_at));
                end
            end
            if (resp_valid && !resp_ready) begin
                chk("req_ready_stall", req_ready, 1'b0);
                stall_edges++;
                held_wr    = resp_write;
                held_addr  = resp_addr;
                held_data  = resp_data;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp_d);
        int   tries = 0;
        exp_t e;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        forever begin
            @(negedge clk);
            #1;
            if (req_ready && !rst) begin
                e.wr       = w;
                e.addr     = a;
                e.data     = exp_d;
                e.acc_edge = cyc + 1;
                e.stall_at = stall_edges;
                sb.push_back(e);
                break;
            end
            tries++;
            if (tries > 50) begin
                n_total++;
                $display("FAIL issue_timeout: got req_ready %b expected 1 within 50 cycles", req_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || resp_valid) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 100) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int s0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b1, 16'h0040, 16'h5555, 16'h5555);
        drain();

        // Reset held two edges with a store present: the store must be ignored.
        rst       = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0040;
        req_wdata = 16'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_write", resp_write, 1'b0);
        chk("rst_resp_addr", resp_addr, 16'h0000);
        chk("rst_resp_data", resp_data, 16'h0000);
        chk("rst_inflight", inflight, 4'd0);
        chk("rst_req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        issue(1'b0, 16'h0040, 16'h0000, 16'h5555);
        drain();

        // Store then load of the same word, back to back.
        issue(1'b1, 16'h0010, 16'h1234, 16'h1234);
        issue(1'b0, 16'h0010, 16'h0000, 16'h1234);
        drain();

        // Streaming: 4 stores then 4 loads, inflight fills to 4 and stays there.
        for (int k = 0; k < 8; k++) begin
            logic [15:0] a;
            logic [15:0] d;
            a = 16'h0020 + 16'(2 * (k % 4));
            d = 16'hA000 + 16'(k % 4);
            issue(k < 4, a, d, d);
            chk("stream_inflight", inflight, (k + 1 < LAT) ? k + 1 : LAT);
        end
        drain();

        // Back-pressure: drop resp_ready for 3 cycles mid-stream.
        s0 = stall_edges;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    issue(1'b0, 16'h0020 + 16'(2 * (k % 4)), 16'h0000, 16'hA000 + 16'(k % 4));
                end
            end
            begin
                int k = 0;
                do begin
                    @(posedge clk);
                    #1;
                    k++;
                end while (!resp_valid && k < 30);
                resp_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                resp_ready = 1'b1;
            end
        join
        drain();
        chk("stall_edges", stall_edges - s0, 3);

        // Alias: 0x0800 and 0x0000 map to the same word.
        issue(1'b1, 16'h0800, 16'hBEEF, 16'hBEEF);
        issue(1'b0, 16'h0000, 16'h0000, 16'hBEEF);
        drain();

        // Reset with three loads in flight.
        issue(1'b1, 16'h0060, 16'h7777, 16'h7777);
        drain();
        issue(1'b0, 16'h0020, 16'h0000, 16'hA000);
        issue(1'b0, 16'h0022, 16'h0000, 16'hA001);
        issue(1'b0, 16'h0024, 16'h0000, 16'hA002);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_resp_valid", resp_valid, 1'b0);
        chk("rst2_inflight", inflight, 4'd0);
        repeat (8) @(posedge clk);
        #1;
        issue(1'b0, 16'h0060, 16'h0000, 16'h7777);
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
